// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 2**ADDR_W-entry byte FIFO placed in front of a UART transmitter.
// It launches one byte per frame with a single-cycle o_TX_DV pulse, then waits
// for i_TX_Done before launching the next byte. After reset it resynchronises
// to the transmitter, because the transmitter has no reset of its own.
module uart_tx_fifo #(
  parameter int ADDR_W       = 4,
  parameter int CLKS_PER_BIT = 217
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Wr_DV,
  input  logic [7:0]        i_Wr_Byte,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow,
  output logic              o_Busy,
  output logic              o_TX_DV,
  output logic [7:0]        o_TX_Byte,
  input  logic              i_TX_Active,
  input  logic              i_TX_Done
);

  localparam int                DEPTH      = 1 << ADDR_W;
  localparam logic [15:0]       SYNC_LIMIT = 16'(CLKS_PER_BIT);
  localparam logic [ADDR_W-1:0] PTR_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE    = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_SYNC      = 2'd0,
    S_IDLE      = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  logic [7:0]        mem_q [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [15:0]       sync_cnt_q, sync_cnt_d;
  logic              tx_dv_q, tx_dv_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              overflow_q, overflow_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              busy_q, busy_d;

  logic              wr_accept;
  logic              pop;

  // Next-state logic for the FIFO bookkeeping, the launch FSM and all registered outputs.
  always_comb begin
    wr_accept  = i_Wr_DV && !count_q[ADDR_W];
    pop        = 1'b0;
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;

    case (state_q)
      S_SYNC: begin
        if (i_TX_Active) begin
          sync_cnt_d = '0;
        end else if (sync_cnt_q != 16'hFFFF) begin
          sync_cnt_d = sync_cnt_q + 16'd1;
        end
        if (i_TX_Done || (!i_TX_Active && (sync_cnt_q >= SYNC_LIMIT))) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (i_TX_Done) begin
          if (count_q != '0) begin
            pop = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d    = S_SYNC;
        sync_cnt_d = '0;
      end
    endcase

    wr_ptr_d   = wr_accept ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    count_d    = count_q + (wr_accept ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
    overflow_d = i_Wr_DV && count_q[ADDR_W];
    tx_dv_d    = pop;
    tx_byte_d  = pop ? mem_q[rd_ptr_q] : tx_byte_q;
    full_d     = count_d[ADDR_W];
    empty_d    = (count_d == '0);
    busy_d     = (state_d != S_IDLE);
  end

  // State and output registers, cleared by the synchronous reset.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= S_SYNC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sync_cnt_q <= '0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= 8'h00;
      overflow_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sync_cnt_q <= sync_cnt_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
      overflow_q <= overflow_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      busy_q     <= busy_d;
    end
  end

  // Storage array; no reset is needed because the pointers and count define validity.
  always_ff @(posedge i_Clock) begin
    if (wr_accept && !i_Reset) begin
      mem_q[wr_ptr_q] <= i_Wr_Byte;
    end
  end

  assign o_Full     = full_q;
  assign o_Empty    = empty_q;
  assign o_Count    = count_q;
  assign o_Overflow = overflow_q;
  assign o_Busy     = busy_q;
  assign o_TX_DV    = tx_dv_q;
  assign o_TX_Byte  = tx_byte_q;

endmodule
